result_buffer_ctrl: RTL and testbench

- Parametrised, multi-port result buffer. Successor to the fixed 8-entry ResultBufferEntryType array.
- Holds speculative results of skipped/pending instructions in a circular queue.
- Allocates at dispatch, accepts out-of-order writeback by index, serves NUM_RD operand lookups, retires in order.
- Sits between the skip table (which stores the indices) and the register-file writeback.

---
 rtl/result_buffer_ctrl_pkg.sv | 17 +
 rtl/result_buffer_ctrl_ptr.sv | 34 +++
 rtl/result_buffer_ctrl.sv | 142 ++++++++++++++
 tb/tb_result_buffer_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_buffer_ctrl_pkg.sv
// Shared types for the speculative result buffer: default sizing, index type
// and the per-entry status flags with their reset value.
package result_buffer_ctrl_pkg;

    localparam int unsigned RESULT_BUFFER_SIZE = 8;
    localparam int unsigned RB_IDX_W           = $clog2(RESULT_BUFFER_SIZE);

    typedef logic [RB_IDX_W-1:0] RbIdxType;

    typedef struct packed {
        logic alloc;
        logic valid;
    } RbFlagsType;

    localparam RbFlagsType RbFlagsDefault = '{alloc: 1'b0, valid: 1'b0};

endpackage

// File: rtl/result_buffer_ctrl_ptr.sv
// Wrapping circular-buffer pointer with increment enable and synchronous clear.
// DEPTH is a power of two, so natural overflow of the IDX_W counter is the wrap.
module rb_wrap_ptr #(
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] ptr_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/result_buffer_ctrl.sv
// Circular result buffer: in-order allocate/retire, out-of-order writeback by
// index, combinational operand lookup with same-cycle writeback bypass.
module result_buffer_ctrl
    import result_buffer_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = RESULT_BUFFER_SIZE,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     alloc_req,
    output logic                     alloc_gnt,
    output logic [IDX_W-1:0]         alloc_idx,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     retire_req,
    output logic                     retire_vld,
    output logic [DATA_W-1:0]        retire_data,
    output logic [IDX_W-1:0]         retire_idx,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [IDX_W:0]           count
);

    RbFlagsType        flags_q [DEPTH];
    RbFlagsType        flags_d [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [IDX_W:0]    count_q, count_d;
    logic [IDX_W-1:0]  head_ptr, tail_ptr;
    logic              wr_legal, head_byp, retire_fire;

    assign full      = (count_q == (IDX_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign alloc_gnt = alloc_req & ~full & ~flush;
    assign alloc_idx = tail_ptr;

    // Flush suppresses the write, so it also disables bypass on lookups.
    assign wr_legal    = wr_en & flags_q[wr_idx].alloc & ~flush;
    assign head_byp    = wr_legal & (wr_idx == head_ptr);
    assign retire_vld  = ~empty & (flags_q[head_ptr].valid | head_byp);
    assign retire_idx  = head_ptr;
    assign retire_fire = retire_req & retire_vld & ~flush;

    always_comb begin
        retire_data = '0;
        if (retire_vld) begin
            retire_data = head_byp ? wr_data : data_q[head_ptr];
        end
    end

    always_comb begin
        logic [IDX_W-1:0] sel;
        sel      = '0;
        rd_data  = '0;
        rd_valid = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            sel = rd_idx[p*IDX_W +: IDX_W];
            if (wr_legal && (wr_idx == sel)) begin
                rd_valid[p]                 = 1'b1;
                rd_data[p*DATA_W +: DATA_W] = wr_data;
            end else if (flags_q[sel].alloc && flags_q[sel].valid) begin
                rd_valid[p]                 = 1'b1;
                rd_data[p*DATA_W +: DATA_W] = data_q[sel];
            end
        end
    end

    // Alloc hits tail, retire hits head; they only coincide when empty or full,
    // where one of the two is impossible, so the update order is safe.
    always_comb begin
        flags_d = flags_q;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                flags_d[i] = RbFlagsDefault;
            end
        end else begin
            if (alloc_gnt) begin
                flags_d[tail_ptr] = '{alloc: 1'b1, valid: 1'b0};
            end
            if (wr_legal) begin
                flags_d[wr_idx].valid = 1'b1;
            end
            if (retire_fire) begin
                flags_d[head_ptr] = RbFlagsDefault;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (alloc_gnt && !retire_fire) begin
            count_d = count_q + (IDX_W+1)'(1);
        end else if (!alloc_gnt && retire_fire) begin
            count_d = count_q - (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                flags_q[i] <= RbFlagsDefault;
            end
            count_q <= '0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_legal) begin
            data_q[wr_idx] <= wr_data;
        end
    end

    rb_wrap_ptr #(.IDX_W(IDX_W)) u_head_ptr (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .clr_i  (flush),
        .inc_i  (retire_fire),
        .ptr_o  (head_ptr)
    );

    rb_wrap_ptr #(.IDX_W(IDX_W)) u_tail_ptr (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .clr_i  (flush),
        .inc_i  (alloc_gnt),
        .ptr_o  (tail_ptr)
    );

endmodule

// File: tb/tb_result_buffer_ctrl.sv
// Self-checking bench for result_buffer_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_result_buffer_ctrl;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int NUM_RD = 2;
    localparam int IDX_W  = 3;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic                     alloc_req, alloc_gnt;
    logic [IDX_W-1:0]         alloc_idx;
    logic                     wr_en;
    logic [IDX_W-1:0]         wr_idx;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*IDX_W-1:0]  rd_idx;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     retire_req, retire_vld;
    logic [DATA_W-1:0]        retire_data;
    logic [IDX_W-1:0]         retire_idx;
    logic                     flush, full, empty;
    logic [IDX_W:0]           count;

    result_buffer_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_RD(NUM_RD)) dut (
        .CLK(CLK), .nRST(nRST),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .retire_req(retire_req), .retire_vld(retire_vld),
        .retire_data(retire_data), .retire_idx(retire_idx),
        .flush(flush), .full(full), .empty(empty), .count(count)
    );

    // Second configuration: 16 entries, 3 lookup ports.
    logic        d_alloc_req, d_alloc_gnt, d_retire_vld, d_full, d_empty;
    logic        d_zero1 = 1'b0;
    logic [3:0]  d_zero_idx = '0;
    logic [31:0] d_zero_data = '0;
    logic [11:0] d_rd_idx = '0;
    logic [3:0]  d_alloc_idx, d_retire_idx;
    logic [95:0] d_rd_data;
    logic [2:0]  d_rd_valid;
    logic [31:0] d_retire_data;
    logic [4:0]  d_count;

    result_buffer_ctrl #(.DEPTH(16), .DATA_W(32), .NUM_RD(3)) dut16 (
        .CLK(CLK), .nRST(nRST),
        .alloc_req(d_alloc_req), .alloc_gnt(d_alloc_gnt), .alloc_idx(d_alloc_idx),
        .wr_en(d_zero1), .wr_idx(d_zero_idx), .wr_data(d_zero_data),
        .rd_idx(d_rd_idx), .rd_data(d_rd_data), .rd_valid(d_rd_valid),
        .retire_req(d_zero1), .retire_vld(d_retire_vld),
        .retire_data(d_retire_data), .retire_idx(d_retire_idx),
        .flush(d_zero1), .full(d_full), .empty(d_empty), .count(d_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: allocated indices in program order, per-index valid/data.
    int          q[$];
    bit          mv[DEPTH];
    logic [31:0] md[DEPTH];
    int          mtail;

    function automatic bit m_is_alloc(int idx);
        foreach (q[k]) if (q[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_wr_ok();
        return wr_en && !flush && m_is_alloc(int'(wr_idx));
    endfunction

    function automatic bit m_rdv(int idx);
        return (m_wr_ok() && int'(wr_idx) == idx) || (m_is_alloc(idx) && mv[idx]);
    endfunction

    function automatic logic [31:0] m_rdd(int idx);
        if (!m_rdv(idx)) return 32'h0;
        if (m_wr_ok() && int'(wr_idx) == idx) return wr_data;
        return md[idx];
    endfunction

    function automatic int m_head();
        return (q.size() > 0) ? q[0] : mtail;
    endfunction

    function automatic bit m_rvld();
        return (q.size() > 0) && m_rdv(q[0]);
    endfunction

    function automatic bit m_gnt();
        return alloc_req && (q.size() < DEPTH) && !flush;
    endfunction

    task automatic m_clear();
        q.delete();
        foreach (mv[i]) mv[i] = 1'b0;
        mtail = 0;
    endtask

    task automatic tick();
        bit g, w, f;
        g = m_gnt();
        w = m_wr_ok();
        f = retire_req && m_rvld() && !flush;
        if (flush) begin
            m_clear();
        end else begin
            if (w) begin
                mv[wr_idx] = 1'b1;
                md[wr_idx] = wr_data;
            end
            if (f) begin
                mv[q[0]] = 1'b0;
                void'(q.pop_front());
            end
            if (g) begin
                q.push_back(mtail);
                mv[mtail] = 1'b0;
                mtail = (mtail + 1) % DEPTH;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req = 0; wr_en = 0; wr_idx = '0; wr_data = '0;
        rd_idx = '0; retire_req = 0; flush = 0; d_alloc_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 0;
        m_clear();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic alloc_n(int n);
        alloc_req = 1;
        repeat (n) tick();
        alloc_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0;
        m_clear();
        @(negedge CLK);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", alloc_gnt); end
        checks++; if (retire_vld !== 1'b0) begin errors++; $display("FAIL reset_rvld got %b exp 0", retire_vld); end
        checks++; if (rd_valid !== 2'b00 || rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd got v=%b d=%h exp 0", rd_valid, rd_data); end
        checks++; if (d_empty !== 1'b1 || d_rd_valid !== 3'b000 || d_rd_data !== 96'h0 || d_retire_vld !== 1'b0 || d_retire_data !== 32'h0 || d_retire_idx !== 4'd0) begin
            errors++; $display("FAIL reset16 got empty=%b rdv=%b rvld=%b ridx=%0d", d_empty, d_rd_valid, d_retire_vld, d_retire_idx);
        end
        @(negedge CLK);
        nRST = 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_req = 1;
            @(negedge CLK);
            checks++; if (alloc_gnt !== 1'b1 || alloc_idx !== IDX_W'(i)) begin
                errors++; $display("FAIL fill_gnt got gnt=%b idx=%0d exp gnt=1 idx=%0d", alloc_gnt, alloc_idx, i);
            end
            tick();
        end
        @(negedge CLK);
        checks++; if (alloc_gnt !== 1'b0 || full !== 1'b1 || count !== 4'd8) begin
            errors++; $display("FAIL fill_full got gnt=%b full=%b count=%0d exp 0 1 8", alloc_gnt, full, count);
        end
        tick();
        alloc_req = 0;
    endtask

    task automatic test_inorder_retire();
        do_reset();
        alloc_n(3);
        wr_en = 1; wr_idx = 3'd2; wr_data = 32'hDEAD;
        @(negedge CLK);
        checks++; if (retire_vld !== 1'b0) begin errors++; $display("FAIL ooo_rvld got %b exp 0", retire_vld); end
        tick();
        wr_idx = 3'd0; wr_data = 32'h1234;
        tick();
        wr_en = 0;
        @(negedge CLK);
        checks++; if (retire_vld !== 1'b1 || retire_data !== 32'h1234 || retire_idx !== 3'd0) begin
            errors++; $display("FAIL head_ready got vld=%b data=%h idx=%0d exp 1 1234 0", retire_vld, retire_data, retire_idx);
        end
        retire_req = 1;
        tick();
        @(negedge CLK);
        checks++; if (retire_vld !== 1'b0 || retire_idx !== 3'd1 || retire_data !== 32'h0) begin
            errors++; $display("FAIL head_stall got vld=%b idx=%0d data=%h exp 0 1 0", retire_vld, retire_idx, retire_data);
        end
        tick();
        retire_req = 0;
        @(negedge CLK);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", count); end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_idx = 3'd1; wr_data = 32'hBEEF;
        rd_idx = {3'd2, 3'd1};
        @(negedge CLK);
        checks++; if (rd_valid !== 2'b11 || rd_data[31:0] !== 32'hBEEF || rd_data[63:32] !== 32'hDEAD) begin
            errors++; $display("FAIL bypass got v=%b d=%h exp 11 0000dead0000beef", rd_valid, rd_data);
        end
        tick();
        wr_idx = 3'd5; wr_data = 32'h5555;
        rd_idx = {3'd5, 3'd1};
        @(negedge CLK);
        checks++; if (rd_valid !== 2'b01 || rd_data[63:32] !== 32'h0) begin
            errors++; $display("FAIL unalloc_byp got v=%b d=%h exp v=01 hi=0", rd_valid, rd_data);
        end
        tick();
        wr_en = 0;
        @(negedge CLK);
        checks++; if (rd_valid !== 2'b01 || count !== 4'd2 || rd_data[31:0] !== 32'hBEEF) begin
            errors++; $display("FAIL unalloc_wr got v=%b count=%0d d=%h exp 01 2 beef", rd_valid, count, rd_data);
        end
        rd_idx = '0;
    endtask

    task automatic test_full_retire();
        do_reset();
        alloc_n(DEPTH);
        wr_en = 1; wr_idx = 3'd0; wr_data = 32'h77;
        tick();
        wr_en = 0;
        alloc_req = 1; retire_req = 1;
        @(negedge CLK);
        checks++; if (alloc_gnt !== 1'b0 || retire_vld !== 1'b1) begin
            errors++; $display("FAIL full_retire got gnt=%b rvld=%b exp 0 1", alloc_gnt, retire_vld);
        end
        tick();
        retire_req = 0;
        @(negedge CLK);
        checks++; if (count !== 4'd7 || alloc_gnt !== 1'b1 || alloc_idx !== 3'd0) begin
            errors++; $display("FAIL wrap_alloc got count=%0d gnt=%b idx=%0d exp 7 1 0", count, alloc_gnt, alloc_idx);
        end
        tick();
        alloc_req = 0;
        @(negedge CLK);
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL refill got count=%0d full=%b exp 8 1", count, full); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(4);
        wr_en = 1; wr_idx = 3'd1; wr_data = 32'h11; tick();
        wr_idx = 3'd3; wr_data = 32'h33; tick();
        wr_en = 0;
        flush = 1; alloc_req = 1; rd_idx = {3'd3, 3'd1};
        @(negedge CLK);
        checks++; if (alloc_gnt !== 1'b0 || rd_valid !== 2'b11 || rd_data !== {32'h33, 32'h11}) begin
            errors++; $display("FAIL flush_cycle got gnt=%b v=%b d=%h exp 0 11 000000330000 0011", alloc_gnt, rd_valid, rd_data);
        end
        tick();
        flush = 0; alloc_req = 0;
        @(negedge CLK);
        checks++; if (empty !== 1'b1 || count !== 4'd0 || retire_idx !== 3'd0 || alloc_idx !== 3'd0 || rd_valid !== 2'b00) begin
            errors++; $display("FAIL post_flush got empty=%b count=%0d head=%0d tail=%0d v=%b exp 1 0 0 0 00",
                               empty, count, retire_idx, alloc_idx, rd_valid);
        end
        rd_idx = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_n(4);
        wr_en = 1; wr_idx = 3'd0; wr_data = 32'hAA; tick();
        wr_en = 0;
        rd_idx = {3'd1, 3'd0};
        @(negedge CLK);
        #2 nRST = 0;
        #1;
        checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 || retire_vld !== 1'b0 ||
                      rd_valid !== 2'b00 || alloc_idx !== 3'd0 || retire_data !== 32'h0) begin
            errors++; $display("FAIL async_rst got empty=%b count=%0d rvld=%b v=%b tail=%0d exp 1 0 0 00 0",
                               empty, count, retire_vld, rd_valid, alloc_idx);
        end
        m_clear();
        @(negedge CLK);
        nRST = 1;
        @(posedge CLK);
        #1;
        rd_idx = '0;
    endtask

    task automatic test_random();
        int idx;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            alloc_req  = ($urandom_range(0, 2) != 0);
            wr_en      = ($urandom_range(0, 3) != 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) wr_idx = IDX_W'(q[$urandom_range(0, q.size() - 1)]);
            else wr_idx = IDX_W'($urandom);
            wr_data    = $urandom;
            rd_idx     = NUM_RD*IDX_W'($urandom);
            retire_req = ($urandom_range(0, 1) != 0);
            flush      = ($urandom_range(0, 49) == 0);
            @(negedge CLK);
            checks++; if (count !== (IDX_W+1)'(q.size())) begin errors++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, count, q.size()); end
            checks++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
                errors++; $display("FAIL rnd_flags c=%0d got full=%b empty=%b size=%0d", c, full, empty, q.size());
            end
            checks++; if (alloc_gnt !== m_gnt() || alloc_idx !== IDX_W'(mtail)) begin
                errors++; $display("FAIL rnd_alloc c=%0d got gnt=%b idx=%0d exp %b %0d", c, alloc_gnt, alloc_idx, m_gnt(), mtail);
            end
            checks++; if (retire_vld !== m_rvld() || retire_idx !== IDX_W'(m_head()) ||
                          retire_data !== (m_rvld() ? m_rdd(m_head()) : 32'h0)) begin
                errors++; $display("FAIL rnd_retire c=%0d got vld=%b idx=%0d data=%h exp vld=%b idx=%0d",
                                   c, retire_vld, retire_idx, retire_data, m_rvld(), m_head());
            end
            for (int p = 0; p < NUM_RD; p++) begin
                idx = int'(rd_idx[p*IDX_W +: IDX_W]);
                checks++; if (rd_valid[p] !== m_rdv(idx) || rd_data[p*DATA_W +: DATA_W] !== m_rdd(idx)) begin
                    errors++; $display("FAIL rnd_rd c=%0d p=%0d got v=%b d=%h exp v=%b d=%h",
                                       c, p, rd_valid[p], rd_data[p*DATA_W +: DATA_W], m_rdv(idx), m_rdd(idx));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_deep_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            d_alloc_req = 1;
            @(negedge CLK);
            checks++; if (d_alloc_gnt !== 1'b1 || d_alloc_idx !== 4'(i)) begin
                errors++; $display("FAIL fill16 got gnt=%b idx=%0d exp 1 %0d", d_alloc_gnt, d_alloc_idx, i);
            end
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        checks++; if (d_alloc_gnt !== 1'b0 || d_full !== 1'b1 || d_count !== 5'd16 || d_empty !== 1'b0) begin
            errors++; $display("FAIL full16 got gnt=%b full=%b count=%0d exp 0 1 16", d_alloc_gnt, d_full, d_count);
        end
        d_alloc_req = 0;
    endtask

    initial begin
        idle_inputs();
        m_clear();
        test_reset();
        test_fill();
        test_inorder_retire();
        test_bypass();
        test_full_retire();
        test_flush();
        test_async_reset();
        test_random();
        test_deep_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
